inv_mix_columns_seq: RTL and testbench
======================================

# inv_mix_columns_seq

Sequential AES InvMixColumns stage for the decryption datapath, the inverse of the existing MixColumns block. It accepts a 128-bit state over a valid/ready handshake and multiplies each column in GF(2^8) by the inverse matrix {0e,0b,0d,09} (rows are rotations). By default it processes one column per cycle and holds the result until the downstream stage accepts it. It sits between InvShiftRows/InvSubBytes and AddRoundKey in the round loop.

## Interface
- DATA_W, 128, state width; only 128 is supported.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  state_in is valid this cycle.
- in_ready  out  1  block can accept state_in this cycle.
- state_in  in  128  input state.
- out_valid  out  1  state_out holds a finished result.
- out_ready  in  1  downstream accepts state_out.
- state_out  out  128  result, registered.

## Operation
- Byte mapping is column-major, MSB first:
  - Column c occupies state[127-32c -: 32].
  - Row 0 is the top byte of each column.
- For each column (a0..a3), output byte r = 0e·a(r) ^ 0b·a(r+1) ^ 0d·a(r+2) ^ 09·a(r+3), with indices mod 4.
- GF multiply uses xtime with the reduction polynomial 0x11B. All intermediate values are 8 bits, with no wider temporaries.
- FSM states are IDLE, BUSY and HOLD. Reset enters IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture state_in into the input register, clear col to 0, and go to BUSY.
- BUSY:
  - Each cycle, compute column col from the input register and write it into the matching 32 bits of state_out.
  - col increments by 1 per cycle. When col is 3, go to HOLD after the write. col wraps 3→0.
- HOLD:
  - out_valid=1. state_out and out_valid stay stable until out_ready.
  - If out_ready and in_valid are both high in the same cycle, the output handshake completes and the new input is captured. The FSM goes directly to BUSY, so there is no IDLE bubble.
  - If only out_ready is high, go to IDLE.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). This is combinational from state and out_ready.
- in_valid is ignored whenever in_ready=0, i.e. in BUSY, or in HOLD without out_ready. No input is lost or corrupted in those cases.
- state_in may change freely once it has been captured.

## Timing
- Reset values: state=IDLE, col=0, out_valid=0, in_ready=1 (combinational from IDLE), state_out=128'h0, input register=0.
- Reset asserted mid-operation (BUSY or HOLD) aborts the block on the next edge and returns to IDLE. The partial result is discarded and state_out clears to 0.
- Serial mode:
  - Input accepted at edge N gives out_valid=1 after edge N+4.
  - Sustained throughput is 1 block per 5 cycles when out_ready is held high.
- During BUSY, state_out is partially updated and must not be sampled. Only out_valid qualifies state_out.
- The output handshake completes on any edge where out_valid && out_ready.

## Configuration
- INV_MIX_COLUMNS_PARALLEL_EN:
  - Defined: four column units compute all columns in a single BUSY cycle, so the transition is BUSY→HOLD after 1 cycle. Latency is out_valid after edge N+1; throughput is 1 block per 2 cycles. col is unused and stays 0.
  - Undefined (default): one shared column unit, 4 BUSY cycles, as described above.
  - Ports, reset values and handshake rules are identical in both builds.

## Structure
- Shared package aes_pkg holds:
  - The xtime function and the gf_mul8 constant multiply function for 02/03/09/0b/0d/0e.
  - The FSM state enum type.
  - The polynomial constant 8'h1B.
  - The column slice helper.
- Forward MixColumns and this block both import aes_pkg.
- Sub-module inv_mix_column: purely combinational, 32-bit column in and 32-bit column out.
  - It is instantiated once in serial mode and four times under INV_MIX_COLUMNS_PARALLEL_EN.

## Test plan
- Reset test: drive rst high for 2 cycles with in_valid=1, then check out_valid=0, in_ready=1 and state_out=0.
- Known columns, with out_ready=1:
  - Input 8e4da1bc_9fdc589d_01010101_c6c6c6c6 → out_valid exactly 4 cycles after accept (1 cycle in parallel build).
  - Required state_out = db135345_f20a225c_01010101_c6c6c6c6.
- Backpressure: use input 4d7ebdf8_d5d5d7d6_4d7ebdf8_d5d5d7d6 and hold out_ready=0 for 10 cycles.
  - state_out must stay stable at 2d26314c_d4d4d4d5_2d26314c_d4d4d4d5, with in_ready=0.
  - in_valid pulses during HOLD must be ignored.
- Back-to-back: two blocks with in_valid and out_ready constantly high.
  - The second block must be accepted in the same cycle the first completes (HOLD→BUSY), with no IDLE cycle.
  - Both results must be correct.
- Mid-operation reset: assert rst on the second BUSY cycle, then check IDLE, out_valid=0 and state_out=0.
  - A following block must then produce the correct result.
- Round-trip: run 1000 random states through forward MixColumns and then this block.
  - The output must equal the original input every time.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) constant multiplies, column slicing and the
// InvMixColumns sequencer state type.
package aes_pkg;

  localparam int unsigned DATA_W   = 128;
  localparam int unsigned COL_W    = 32;
  localparam int unsigned NUM_COLS = 4;
  localparam logic [7:0]  AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } imc_state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1; stays within 8 bits.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  // Constant multiply for the MixColumns/InvMixColumns coefficients.
  function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (k)
      8'h01:   gf_mul8 = a;
      8'h02:   gf_mul8 = x2;
      8'h03:   gf_mul8 = x2 ^ a;
      8'h09:   gf_mul8 = x8 ^ a;
      8'h0b:   gf_mul8 = x8 ^ x2 ^ a;
      8'h0d:   gf_mul8 = x8 ^ x4 ^ a;
      8'h0e:   gf_mul8 = x8 ^ x4 ^ x2;
      default: gf_mul8 = 8'h00;
    endcase
  endfunction

  // Column c of a column-major state; column 0 is the most significant word.
  function automatic logic [COL_W-1:0] col_slice(input logic [DATA_W-1:0] s,
                                                 input logic [1:0] c);
    case (c)
      2'd0:    col_slice = s[127:96];
      2'd1:    col_slice = s[95:64];
      2'd2:    col_slice = s[63:32];
      default: col_slice = s[31:0];
    endcase
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns on one 32-bit column (row 0 in the top byte).
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  // Each output row uses the {0e,0b,0d,09} row rotated by its index.
  assign col_o[31:24] = gf_mul8(a0, 8'h0e) ^ gf_mul8(a1, 8'h0b) ^ gf_mul8(a2, 8'h0d) ^ gf_mul8(a3, 8'h09);
  assign col_o[23:16] = gf_mul8(a1, 8'h0e) ^ gf_mul8(a2, 8'h0b) ^ gf_mul8(a3, 8'h0d) ^ gf_mul8(a0, 8'h09);
  assign col_o[15:8]  = gf_mul8(a2, 8'h0e) ^ gf_mul8(a3, 8'h0b) ^ gf_mul8(a0, 8'h0d) ^ gf_mul8(a1, 8'h09);
  assign col_o[7:0]   = gf_mul8(a3, 8'h0e) ^ gf_mul8(a0, 8'h0b) ^ gf_mul8(a1, 8'h0d) ^ gf_mul8(a2, 8'h09);

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns with valid/ready handshake.
// INV_MIX_COLUMNS_PARALLEL_EN: all four columns in one BUSY cycle instead of one per cycle.
module inv_mix_columns_seq
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] state_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] state_out
);

  imc_state_e        state_q, state_d;
  logic [1:0]        col_q, col_d;
  logic [DATA_W-1:0] in_q, in_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;

`ifdef INV_MIX_COLUMNS_PARALLEL_EN
  logic [DATA_W-1:0] res_full;

  for (genvar g = 0; g < NUM_COLS; g++) begin : g_col
    inv_mix_column u_col (
      .col_i (in_q[DATA_W-1-COL_W*g -: COL_W]),
      .col_o (res_full[DATA_W-1-COL_W*g -: COL_W])
    );
  end
`else
  logic [COL_W-1:0] col_in, col_res;

  assign col_in = col_slice(in_q, col_q);

  inv_mix_column u_col (
    .col_i (col_in),
    .col_o (col_res)
  );
`endif

  // Ready in HOLD only once the current result is being taken, so a new block
  // can be captured on the same edge with no idle bubble.
  assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign out_valid = out_valid_q;
  assign state_out = out_q;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    in_d        = in_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_d    = state_in;
          col_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
`ifdef INV_MIX_COLUMNS_PARALLEL_EN
        out_d       = res_full;
        out_valid_d = 1'b1;
        state_d     = HOLD;
`else
        case (col_q)
          2'd0:    out_d[127:96] = col_res;
          2'd1:    out_d[95:64]  = col_res;
          2'd2:    out_d[63:32]  = col_res;
          default: out_d[31:0]   = col_res;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
`endif
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            in_d    = state_in;
            col_d   = 2'd0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= 2'd0;
      in_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      in_q        <= in_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed and round-trip checks for inv_mix_columns_seq.
module tb_inv_mix_columns_seq;

`ifdef INV_MIX_COLUMNS_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif

  localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V1_EXP = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'h4d7ebdf8_d5d5d7d6_4d7ebdf8_d5d5d7d6;
  localparam logic [127:0] V2_EXP = 128'h2d26314c_d4d4d4d5_2d26314c_d4d4d4d5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  int n_tests = 0;
  int n_fail  = 0;

  inv_mix_columns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Forward MixColumns model, used to build round-trip stimulus.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    return {fwd_col(s[127:96]), fwd_col(s[95:64]), fwd_col(s[63:32]), fwd_col(s[31:0])};
  endfunction

  // Wait (bounded) for out_valid; returns edges counted after the accept edge.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // One block from IDLE: accept, wait for result, take it, expect IDLE.
  task automatic do_block(input string tag, input logic [127:0] din,
                          input logic [127:0] exp, input bit chk_lat);
    int lat;
    check({tag, "_rdy"}, 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    state_in = din;
    tick();
    in_valid = 1'b0;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    wait_valid(lat);
    check({tag, "_vld"}, 128'(out_valid), 128'd1);
    if (chk_lat) check({tag, "_lat"}, 128'(lat), 128'(LAT));
    check({tag, "_data"}, state_out, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_done"}, 128'(out_valid), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [127:0] r;

    // Reset with in_valid asserted must not start a block
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    state_in  = V1_IN;
    tick();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_vld", 128'(out_valid), 128'd0);
    check("rst_rdy", 128'(in_ready), 128'd1);
    check("rst_out", state_out, 128'h0);

    // Known vector with out_ready held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = V1_IN;
    tick();
    in_valid = 1'b0;
    state_in = '0;
    check("k1_busy", 128'(out_valid), 128'd0);
    wait_valid(lat);
    check("k1_lat", 128'(lat), 128'(LAT));
    check("k1_data", state_out, V1_EXP);
    tick();
    out_ready = 1'b0;
    check("k1_idle", 128'(in_ready), 128'd1);

    // Backpressure: result must hold, in_valid pulses ignored
    in_valid = 1'b1;
    state_in = V2_IN;
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_lat", 128'(lat), 128'(LAT));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      state_in = V1_IN;
      check("bp_hold", state_out, V2_EXP);
      check("bp_rdy", 128'(in_ready), 128'd0);
      tick();
    end
    in_valid = 1'b0;
    check("bp_vld", 128'(out_valid), 128'd1);
    check("bp_data", state_out, V2_EXP);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_done", 128'(out_valid), 128'd0);
    check("bp_idle", 128'(in_ready), 128'd1);

    // Back-to-back: second block accepted on the first block's completion edge
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = V1_IN;
    tick();
    state_in = V2_IN;
    wait_valid(lat);
    check("b2b_lat1", 128'(lat), 128'(LAT));
    check("b2b_data1", state_out, V1_EXP);
    check("b2b_rdy", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    state_in = '0;
    check("b2b_busy_vld", 128'(out_valid), 128'd0);
    check("b2b_busy_rdy", 128'(in_ready), 128'd0);
    wait_valid(lat);
    check("b2b_lat2", 128'(lat), 128'(LAT));
    check("b2b_data2", state_out, V2_EXP);
    tick();
    out_ready = 1'b0;
    check("b2b_idle", 128'(in_ready), 128'd1);

    // Reset on the second BUSY cycle discards the partial result
    in_valid = 1'b1;
    state_in = V1_IN;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_vld", 128'(out_valid), 128'd0);
    check("mid_rdy", 128'(in_ready), 128'd1);
    check("mid_out", state_out, 128'h0);
    do_block("mid_after", V2_IN, V2_EXP, 1'b1);

    // Round trip through the forward model
    for (int i = 0; i < 1000; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      do_block("rt", fwd_mix(r), r, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
